// File: rtl/cci_mpf_shim_edge_fiu_wr_regen.sv
// FIU-side exit of the MPF write path: owns the write-data heap and expands single control flits
// into 1/2/4-beat CCI writes. Optional RAM output register: CCI_MPF_EDGE_FIU_RAM_OUTREG_EN.
//
//  state   | meaning
//  IDLE    | beat 0 of the FIFO head (or a passthrough flit) is issued when FIU has room
//  EMIT    | beats 1..cl_len of the held write packet are issued, one per cycle
module cci_mpf_shim_edge_fiu_wr_regen #(
  parameter int N_WRITE_HEAP_ENTRIES = 32,
  parameter int CTRL_FIFO_DEPTH      = 16,
  parameter int ALMFULL_THRESHOLD    = 8,
  parameter int HDR_W                = 64,
  parameter int IDX_W                = $clog2(N_WRITE_HEAP_ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mpf_c1_valid,
  input  logic [HDR_W-1:0] mpf_c1_hdr,
  input  logic             mpf_c1_is_write,
  input  logic [IDX_W-1:0] mpf_c1_heap_idx,
  output logic             mpf_c1_almfull,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  logic [1:0]       wclnum,
  input  logic [511:0]     wdata,
  output logic             free,
  output logic [IDX_W-1:0] freeidx,
  output logic             fiu_c1_valid,
  output logic [HDR_W-1:0] fiu_c1_hdr,
  output logic [511:0]     fiu_c1_data,
  input  logic             fiu_c1_almfull
);
  // Header layout: address [41:0], cl_len [43:42], sop [44], remaining bits opaque
  localparam int ADDR_LSB = 0;
  localparam int CL_LSB   = 42;
  localparam int SOP_BIT  = 44;
  localparam int PTR_W    = $clog2(CTRL_FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENT_W    = 1 + IDX_W + HDR_W;
  localparam logic [CNT_W-1:0] ALMFULL_LVL = CNT_W'(CTRL_FIFO_DEPTH - ALMFULL_THRESHOLD);
  localparam logic [CNT_W-1:0] FIFO_FULL   = CNT_W'(CTRL_FIFO_DEPTH);

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  logic [ENT_W-1:0] fifo_mem [CTRL_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             almfull_q, almfull_d;
  logic             fifo_empty, pop;
  logic             head_write;
  logic [IDX_W-1:0] head_idx;
  logic [HDR_W-1:0] head_hdr;

  state_t           state_q, state_d;
  logic [HDR_W-1:0] cur_hdr_q, cur_hdr_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [1:0]       beat_q, beat_d;

  logic             iss_vld, iss_last, iss_write;
  logic [HDR_W-1:0] iss_hdr, iss_out_hdr;
  logic [IDX_W-1:0] iss_idx;
  logic [1:0]       iss_beat;

  logic             s1_valid_q, s1_valid_d, s1_free_q, s1_free_d;
  logic [HDR_W-1:0] s1_hdr_q, s1_hdr_d;
  logic [IDX_W-1:0] s1_freeidx_q, s1_freeidx_d;

  logic [511:0]     heap_mem [N_WRITE_HEAP_ENTRIES*4];
  logic [511:0]     rd_data_q;

  assign fifo_empty = (count_q == '0);
  assign {head_write, head_idx, head_hdr} = fifo_mem[rd_ptr_q];
  assign mpf_c1_almfull = almfull_q;

  always_ff @(posedge clk) begin
    if (mpf_c1_valid) fifo_mem[wr_ptr_q] <= {mpf_c1_is_write, mpf_c1_heap_idx, mpf_c1_hdr};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mpf_c1_valid) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)          rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({mpf_c1_valid, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    almfull_d = (count_q >= ALMFULL_LVL) || fiu_c1_almfull;
  end

  // Beat 0 is issued in the pop cycle so the RAM read starts immediately (no bubble between packets)
  always_comb begin
    state_d   = state_q;
    cur_hdr_d = cur_hdr_q;
    cur_idx_d = cur_idx_q;
    beat_d    = beat_q;
    pop       = 1'b0;
    iss_vld   = 1'b0;
    iss_last  = 1'b0;
    iss_write = 1'b1;
    iss_hdr   = cur_hdr_q;
    iss_idx   = cur_idx_q;
    iss_beat  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !fiu_c1_almfull) begin
          pop       = 1'b1;
          iss_vld   = 1'b1;
          iss_hdr   = head_hdr;
          iss_idx   = head_idx;
          iss_beat  = 2'd0;
          iss_write = head_write;
          iss_last  = !head_write || (head_hdr[CL_LSB +: 2] == 2'd0);
          if (!iss_last) begin
            state_d   = ST_EMIT;
            cur_hdr_d = head_hdr;
            cur_idx_d = head_idx;
            beat_d    = 2'd1;
          end
        end
      end
      ST_EMIT: begin
        iss_vld  = 1'b1;
        iss_last = (beat_q == cur_hdr_q[CL_LSB +: 2]);
        beat_d   = beat_q + 2'd1;
        if (iss_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    iss_out_hdr                  = iss_hdr;
    iss_out_hdr[SOP_BIT]         = (iss_beat == 2'd0);
    iss_out_hdr[ADDR_LSB +: 2]   = iss_hdr[ADDR_LSB +: 2] | iss_beat;
    s1_valid_d   = iss_vld;
    s1_hdr_d     = iss_out_hdr;
    s1_free_d    = iss_vld && iss_last && iss_write;
    s1_freeidx_d = s1_free_d ? iss_idx : s1_freeidx_q;
  end

  always_ff @(posedge clk) begin
    if (wen) heap_mem[{widx, wclnum}] <= wdata;
    rd_data_q <= heap_mem[{iss_idx, iss_beat}];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      almfull_q    <= 1'b1;
      state_q      <= ST_IDLE;
      cur_hdr_q    <= '0;
      cur_idx_q    <= '0;
      beat_q       <= '0;
      s1_valid_q   <= 1'b0;
      s1_hdr_q     <= '0;
      s1_free_q    <= 1'b0;
      s1_freeidx_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      almfull_q    <= almfull_d;
      state_q      <= state_d;
      cur_hdr_q    <= cur_hdr_d;
      cur_idx_q    <= cur_idx_d;
      beat_q       <= beat_d;
      s1_valid_q   <= s1_valid_d;
      s1_hdr_q     <= s1_hdr_d;
      s1_free_q    <= s1_free_d;
      s1_freeidx_q <= s1_freeidx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(mpf_c1_valid && !pop && count_q == FIFO_FULL))
        else $fatal(1, "control flit queue overflow");
      assert (!(mpf_c1_valid && mpf_c1_is_write && mpf_c1_hdr[CL_LSB +: 2] == 2'd2))
        else $fatal(1, "cl_len 2 is not a legal write size");
    end
  end

`ifdef CCI_MPF_EDGE_FIU_RAM_OUTREG_EN
  logic [511:0]     rd_data2_q;
  logic             s2_valid_q, s2_valid_d, s2_free_q, s2_free_d;
  logic [HDR_W-1:0] s2_hdr_q, s2_hdr_d;
  logic [IDX_W-1:0] s2_freeidx_q, s2_freeidx_d;

  always_comb begin
    s2_valid_d   = s1_valid_q;
    s2_hdr_d     = s1_hdr_q;
    s2_free_d    = s1_free_q;
    s2_freeidx_d = s1_freeidx_q;
  end

  always_ff @(posedge clk) begin
    rd_data2_q <= rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q   <= 1'b0;
      s2_hdr_q     <= '0;
      s2_free_q    <= 1'b0;
      s2_freeidx_q <= '0;
    end else begin
      s2_valid_q   <= s2_valid_d;
      s2_hdr_q     <= s2_hdr_d;
      s2_free_q    <= s2_free_d;
      s2_freeidx_q <= s2_freeidx_d;
    end
  end

  assign fiu_c1_valid = s2_valid_q;
  assign fiu_c1_hdr   = s2_hdr_q;
  assign fiu_c1_data  = rd_data2_q;
  assign free         = s2_free_q;
  assign freeidx      = s2_freeidx_q;
`else
  assign fiu_c1_valid = s1_valid_q;
  assign fiu_c1_hdr   = s1_hdr_q;
  assign fiu_c1_data  = rd_data_q;
  assign free         = s1_free_q;
  assign freeidx      = s1_freeidx_q;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_edge_fiu_wr_regen.sv
// Bench for cci_mpf_shim_edge_fiu_wr_regen: directed scenarios plus randomized packets checked
// against an expected-beat queue built from each pushed control flit.
`timescale 1ns/1ps
module tb_cci_mpf_shim_edge_fiu_wr_regen;
  localparam int HDR_W = 64;
  localparam int IDX_W = 5;
`ifdef CCI_MPF_EDGE_FIU_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mpf_c1_valid = 1'b0;
  logic [HDR_W-1:0] mpf_c1_hdr = '0;
  logic             mpf_c1_is_write = 1'b0;
  logic [IDX_W-1:0] mpf_c1_heap_idx = '0;
  logic             mpf_c1_almfull;
  logic             wen = 1'b0;
  logic [IDX_W-1:0] widx = '0;
  logic [1:0]       wclnum = '0;
  logic [511:0]     wdata = '0;
  logic             free;
  logic [IDX_W-1:0] freeidx;
  logic             fiu_c1_valid;
  logic [HDR_W-1:0] fiu_c1_hdr;
  logic [511:0]     fiu_c1_data;
  logic             fiu_c1_almfull = 1'b0;

  always #5 clk = ~clk;

  cci_mpf_shim_edge_fiu_wr_regen dut (
    .clk(clk), .reset(reset),
    .mpf_c1_valid(mpf_c1_valid), .mpf_c1_hdr(mpf_c1_hdr), .mpf_c1_is_write(mpf_c1_is_write),
    .mpf_c1_heap_idx(mpf_c1_heap_idx), .mpf_c1_almfull(mpf_c1_almfull),
    .wen(wen), .widx(widx), .wclnum(wclnum), .wdata(wdata),
    .free(free), .freeidx(freeidx),
    .fiu_c1_valid(fiu_c1_valid), .fiu_c1_hdr(fiu_c1_hdr), .fiu_c1_data(fiu_c1_data),
    .fiu_c1_almfull(fiu_c1_almfull)
  );

  typedef struct {
    logic [HDR_W-1:0] hdr;
    logic [511:0]     data;
    bit               is_wr;
    bit               first;
    bit               last;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e_m;
  logic [511:0] heap_m [32][4];
  int           n_chk = 0, n_fail = 0;
  bit           mon_en = 0, rand_fa = 0, prev_open = 0;
  logic         fa_h0 = 1'b0, fa_h1 = 1'b0;
  int           pushed = 0, done = 0, frees_seen = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // FIU almost-full as seen by the DUT at the last two edges
  always @(posedge clk) begin
    fa_h1 = fa_h0;
    fa_h0 = fiu_c1_almfull;
  end

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (fiu_c1_valid) begin
        if (exp_q.size() == 0) chk("unexpected_flit", 512'(fiu_c1_valid), 512'(0));
        else begin
          e_m = exp_q.pop_front();
          chk("hdr", 512'(fiu_c1_hdr), 512'(e_m.hdr));
          if (e_m.is_wr) chk("data", fiu_c1_data, e_m.data);
          chk("free", 512'(free), 512'(e_m.is_wr && e_m.last));
          if (e_m.is_wr && e_m.last) chk("freeidx", 512'(freeidx), 512'(e_m.idx));
          if (e_m.first) chk("start_gate", 512'((LAT == 1) ? fa_h0 : fa_h1), 512'(0));
          if (e_m.last) done++;
          prev_open = !e_m.last;
        end
        if (free) frees_seen++;
      end else begin
        if (prev_open) chk("no_bubble", 512'(fiu_c1_valid), 512'(1));
        chk("free_idle", 512'(free), 512'(0));
        prev_open = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    mpf_c1_valid = 1'b0;
    wen          = 1'b0;
    if (rand_fa) fiu_c1_almfull = ($urandom_range(0, 9) < 3);
  endtask

  task automatic hwrite(input int idx, input int beat, input logic [511:0] d);
    wen    = 1'b1;
    widx   = idx[IDX_W-1:0];
    wclnum = beat[1:0];
    wdata  = d;
    heap_m[idx][beat] = d;
    step();
  endtask

  task automatic push(input logic [41:0] addr, input logic [1:0] cl, input bit wr, input int idx);
    logic [HDR_W-1:0] h;
    exp_t e;
    int nb;
    h = {$urandom, $urandom};
    h[41:0]  = addr;
    h[43:42] = cl;
    mpf_c1_valid    = 1'b1;
    mpf_c1_hdr      = h;
    mpf_c1_is_write = wr;
    mpf_c1_heap_idx = idx[IDX_W-1:0];
    nb = wr ? int'(cl) + 1 : 1;
    for (int k = 0; k < nb; k++) begin
      e.hdr        = h;
      e.hdr[44]    = (k == 0);
      e.hdr[41:0]  = addr + 42'(k);
      e.data       = wr ? heap_m[idx][k] : '0;
      e.is_wr      = wr;
      e.first      = (k == 0);
      e.last       = (k == nb - 1);
      e.idx        = idx[IDX_W-1:0];
      exp_q.push_back(e);
    end
    pushed++;
    step();
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (!fiu_c1_valid && n < max) begin
      step();
      n++;
    end
    chk(tag, 512'(fiu_c1_valid), 512'(1));
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("drain", 512'(exp_q.size()), 512'(0));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int lat, n, f0, wslot, kind, slot;
    logic v0, v1, v2;
    logic [1:0] cl;
    logic [41:0] a;

    repeat (3) step();
    chk("rst_valid", 512'(fiu_c1_valid), 512'(0));
    chk("rst_free", 512'(free), 512'(0));
    chk("rst_freeidx", 512'(freeidx), 512'(0));
    chk("rst_almfull", 512'(mpf_c1_almfull), 512'(1));
    reset  = 1'b0;
    mon_en = 1;
    step();
    step();
    chk("almfull_idle", 512'(mpf_c1_almfull), 512'(0));

    // single line, with accept-to-valid latency
    hwrite(5, 0, rand512());
    push(42'h40, 2'd0, 1, 5);
    lat = 1;
    while (!fiu_c1_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("latency", 512'(lat), 512'(LAT + 1));
    drain(20);

    // four lines, one free
    for (int k = 0; k < 4; k++) hwrite(2, k, rand512());
    f0 = frees_seen;
    push(42'h100, 2'd3, 1, 2);
    drain(30);
    chk("free_4line", 512'(frees_seen - f0), 512'(1));

    // back-to-back 2-line then 1-line
    hwrite(1, 0, rand512());
    hwrite(1, 1, rand512());
    hwrite(3, 0, rand512());
    fiu_c1_almfull = 1'b1;
    push(42'h200, 2'd1, 1, 1);
    push(42'h304, 2'd0, 1, 3);
    step();
    fiu_c1_almfull = 1'b0;
    wait_valid("b2b_start", 10);
    v0 = fiu_c1_valid;
    step();
    v1 = fiu_c1_valid;
    step();
    v2 = fiu_c1_valid;
    chk("b2b_run", 512'({v0, v1, v2}), 512'(3'b111));
    drain(20);

    // FIU almost-full mid-packet does not stall it but holds the next one
    for (int k = 0; k < 4; k++) hwrite(4, k, rand512());
    hwrite(6, 0, rand512());
    push(42'h400, 2'd3, 1, 4);
    push(42'h500, 2'd0, 1, 6);
    wait_valid("hold_start", 10);
    fiu_c1_almfull = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (fiu_c1_valid) n++;
    end
    chk("hold_beats", 512'(n), 512'(3));
    fiu_c1_almfull = 1'b0;
    drain(20);

    // fence between writes
    hwrite(7, 0, rand512());
    hwrite(7, 1, rand512());
    hwrite(8, 0, rand512());
    f0 = frees_seen;
    push(42'h600, 2'd1, 1, 7);
    push(42'h7a5, 2'd0, 0, 11);
    push(42'h800, 2'd0, 1, 8);
    drain(20);
    chk("fence_frees", 512'(frees_seen - f0), 512'(2));

    // almost-full threshold: 7 queued is below, 8 queued is at threshold
    fiu_c1_almfull = 1'b1;
    for (int i = 0; i < 7; i++) push(42'(i * 4), 2'd0, 0, i);
    fiu_c1_almfull = 1'b0;
    step();
    chk("almfull_7", 512'(mpf_c1_almfull), 512'(0));
    drain(40);
    fiu_c1_almfull = 1'b1;
    for (int i = 0; i < 8; i++) push(42'(i * 4), 2'd0, 0, i);
    chk("almfull_8_held", 512'(mpf_c1_almfull), 512'(1));
    fiu_c1_almfull = 1'b0;
    step();
    chk("almfull_8", 512'(mpf_c1_almfull), 512'(1));
    drain(40);

    // reset in the middle of a packet
    for (int k = 0; k < 4; k++) hwrite(9, k, rand512());
    push(42'h900, 2'd3, 1, 9);
    wait_valid("rst_mid_start", 10);
    step();
    mon_en = 0;
    reset  = 1'b1;
    step();
    chk("rst_mid_valid", 512'(fiu_c1_valid), 512'(0));
    chk("rst_mid_almfull", 512'(mpf_c1_almfull), 512'(1));
    chk("rst_mid_free", 512'(free), 512'(0));
    exp_q.delete();
    prev_open = 0;
    pushed = 0;
    done   = 0;
    reset  = 1'b0;
    step();
    mon_en = 1;
    repeat (5) step();

    // randomized packets with random FIU back-pressure
    wslot   = 10;
    rand_fa = 1;
    for (int p = 0; p < 80; p++) begin
      n = 0;
      while (pushed - done >= 6 && n < 300) begin
        step();
        n++;
      end
      if (n >= 300) chk("rand_stall", 512'(pushed - done), 512'(0));
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        push(42'($urandom), 2'd0, 0, $urandom_range(0, 31));
      end else begin
        cl   = (kind < 3) ? 2'd0 : (kind < 5) ? 2'd1 : 2'd3;
        slot = wslot;
        wslot = (wslot + 1) % 32;
        for (int k = 0; k <= int'(cl); k++) hwrite(slot, k, rand512());
        a = 42'({$urandom, $urandom});
        a[1:0] = a[1:0] & ~cl;
        push(a, cl, 1, slot);
      end
      repeat ($urandom_range(0, 2)) step();
    end
    rand_fa = 0;
    fiu_c1_almfull = 1'b0;
    drain(500);
    chk("rand_done", 512'(done), 512'(pushed));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
